serial_parallel_rx: RTL and testbench



---
 rtl/sp_rx_pkg.sv | 19 +
 rtl/sp_shift_align.sv | 36 +++
 rtl/serial_parallel_rx.sv | 130 +++++++++++++
 tb/tb_serial_parallel_rx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sp_rx_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// The optional lock-loss detector is enabled by defining SP_LOSS_DET_EN.
package sp_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } sp_state_e;

    localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
    localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BC_W   = 4;
    localparam int unsigned LOSS_W = 5;

endpackage

// File: rtl/sp_shift_align.sv
// Serial shift register plus word-boundary counter; w is the candidate word
// including the bit currently on data_in.
module sp_shift_align
    import sp_rx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    input  logic              run,
    output logic [WORD_W-1:0] w,
    output logic              word_done
);

    logic [WORD_W-2:0] sr_q, sr_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

    assign w         = {sr_q, data_in};
    assign word_done = run && (bit_cnt_q == BIT_W'(WORD_W - 1));

    always_comb begin
        sr_d      = w[WORD_W-2:0];
        // Held at zero while searching so the first bit after a COM match is bit 0.
        bit_cnt_d = run ? bit_cnt_q + BIT_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: COM-based byte alignment, lock FSM and word outputs.
// Define SP_LOSS_DET_EN to drop lock after LOSS_WORDS consecutive non-COM words.
module serial_parallel_rx
    import sp_rx_pkg::*;
#(
    parameter logic [7:0]  COM_SYM  = COM_SYM_DEF,
    parameter logic [7:0]  IDLE_SYM = IDLE_SYM_DEF,
    parameter int unsigned BC_LOCK  = 4
`ifdef SP_LOSS_DET_EN
    ,
    parameter int unsigned LOSS_WORDS = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       idle_out,
    output logic       active
);

    sp_state_e         state_q, state_d;
    logic [BC_W-1:0]   bc_cnt_q, bc_cnt_d, bc_inc;
    logic [7:0]        data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              idle_q, idle_d;
    logic              active_q, active_d;
    logic [WORD_W-1:0] w;
    logic              word_done;
    logic              run;

    assign run = (state_q != SEARCH);

    sp_shift_align u_shift (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .run       (run),
        .w         (w),
        .word_done (word_done)
    );

`ifdef SP_LOSS_DET_EN
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d, loss_inc;

    always_ff @(posedge clk) begin
        if (reset) loss_cnt_q <= '0;
        else       loss_cnt_q <= loss_cnt_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        bc_cnt_d   = bc_cnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        idle_d     = 1'b0;
        bc_inc     = (bc_cnt_q == '1) ? bc_cnt_q : bc_cnt_q + BC_W'(1);
`ifdef SP_LOSS_DET_EN
        loss_cnt_d = loss_cnt_q;
        loss_inc   = loss_cnt_q + LOSS_W'(1);
`endif
        case (state_q)
            SEARCH: begin
                if (w == COM_SYM) begin
                    bc_cnt_d = BC_W'(1);
                    state_d  = ALIGN;
                end
            end
            ALIGN: begin
                if (word_done) begin
                    if (w == COM_SYM) begin
                        bc_cnt_d = bc_inc;
                        if (bc_inc == BC_W'(BC_LOCK)) state_d = ACTIVE;
                    end else begin
                        bc_cnt_d = '0;
                        state_d  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (word_done) begin
                    data_out_d = w;
                    valid_d    = (w != COM_SYM);
                    idle_d     = (w == IDLE_SYM);
`ifdef SP_LOSS_DET_EN
                    // The word that trips the loss is still emitted above.
                    if (w == COM_SYM) begin
                        loss_cnt_d = '0;
                    end else if (loss_inc == LOSS_W'(LOSS_WORDS)) begin
                        loss_cnt_d = '0;
                        bc_cnt_d   = '0;
                        state_d    = SEARCH;
                    end else begin
                        loss_cnt_d = loss_inc;
                    end
`endif
                end
            end
            default: state_d = SEARCH;
        endcase
        // Registered from the next state so active tracks the lock the cycle after it changes.
        active_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEARCH;
            bc_cnt_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_cnt_q   <= bc_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign idle_out  = idle_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed self-checking bench for serial_parallel_rx; expectations are hand-computed.
// Builds with or without SP_LOSS_DET_EN and expects the matching lock-loss behaviour.
module tb_serial_parallel_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       idle_out;
    logic       active;

    int compared   = 0;
    int mismatched = 0;
    int stray      = 0;
    int pulses     = 0;

    serial_parallel_rx dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .idle_out  (idle_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one bit for one rising edge; outputs are sampled 1 time unit later.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    // MSB first; any valid pulse before the last bit is counted as stray.
    task automatic send_word(input logic [7:0] wd);
        for (int i = 7; i >= 0; i--) begin
            send_bit(wd[i]);
            if (i != 0 && valid_out === 1'b1) stray++;
        end
        $display("word %h -> data_out=%h valid=%b idle=%b active=%b", wd, data_out, valid_out, idle_out, active);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   data_out, 8'h00);
        check({tag, "_valid"},  {7'b0, valid_out}, 8'h00);
        check({tag, "_idle"},   {7'b0, idle_out}, 8'h00);
        check({tag, "_active"}, {7'b0, active}, 8'h00);
    endtask

    initial begin
        // Power-on reset
        @(posedge clk); #1;
        pulse_reset();
        check_all_zero("por");

        // Reset in the middle of a bit stream
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        pulse_reset();
        check_all_zero("rst_mid");

        // Lock acquisition: 3 garbage bits then 4 COMs
        send_bit(0); send_bit(1); send_bit(0);
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        check("lock_3com_active", {7'b0, active}, 8'h00);
        send_word(8'hBC);
        check("lock_4com_active", {7'b0, active}, 8'h01);
        check("lock_4com_valid", {7'b0, valid_out}, 8'h00);
        stray = 0;
        send_word(8'h55);
        check("w55_data", data_out, 8'h55);
        check("w55_valid", {7'b0, valid_out}, 8'h01);
        check("w55_idle", {7'b0, idle_out}, 8'h00);

        // Idle flagging, then a COM which must not pulse
        send_word(8'h7C);
        check("idle_data", data_out, 8'h7C);
        check("idle_valid", {7'b0, valid_out}, 8'h01);
        check("idle_idle", {7'b0, idle_out}, 8'h01);
        send_word(8'hBC);
        check("com_data", data_out, 8'hBC);
        check("com_valid", {7'b0, valid_out}, 8'h00);
        check("com_idle", {7'b0, idle_out}, 8'h00);

        // Back-to-back words
        send_word(8'h01);
        check("b2b_01_data", data_out, 8'h01);
        check("b2b_01_valid", {7'b0, valid_out}, 8'h01);
        send_word(8'h02);
        check("b2b_02_data", data_out, 8'h02);
        check("b2b_02_valid", {7'b0, valid_out}, 8'h01);
        send_word(8'hFF);
        check("b2b_ff_data", data_out, 8'hFF);
        check("b2b_ff_valid", {7'b0, valid_out}, 8'h01);
        check("stray_pulses", 8'(stray), 8'h00);

        // Reset while locked, mid-word
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        pulse_reset();
        check_all_zero("rst_lock");

        // Alignment break: 2 COMs then a non-COM returns to search
        send_word(8'hBC); send_word(8'hBC); send_word(8'hA3);
        check("break_active", {7'b0, active}, 8'h00);
        check("break_valid", {7'b0, valid_out}, 8'h00);
        send_word(8'hBC); send_word(8'hBC); send_word(8'hBC);
        check("relock_3com_active", {7'b0, active}, 8'h00);
        send_word(8'hBC);
        check("relock_4com_active", {7'b0, active}, 8'h01);
        send_word(8'h42);
        check("relock_42_data", data_out, 8'h42);
        check("relock_42_valid", {7'b0, valid_out}, 8'h01);

        // COM clears any loss count, then 16 non-COM words
        send_word(8'hBC);
        check("pre_loss_active", {7'b0, active}, 8'h01);
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            send_word(8'h00);
            if (valid_out === 1'b1 && data_out === 8'h00) pulses++;
            if (k == 14) check("loss_15_active", {7'b0, active}, 8'h01);
        end
        check("loss_pulses", 8'(pulses), 8'd16);
`ifdef SP_LOSS_DET_EN
        check("loss_16_active", {7'b0, active}, 8'h00);
        send_word(8'h00);
        check("after_loss_valid", {7'b0, valid_out}, 8'h00);
`else
        check("loss_16_active", {7'b0, active}, 8'h01);
        send_word(8'h00);
        check("after_loss_valid", {7'b0, valid_out}, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
